// File: rtl/display_pkg.sv
// Shared segment codes, BCD-to-segment decode and FSM state type for the value display.
package display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2,
    SHOW = 2'd3
  } state_t;

  // Decimal digit to segment pattern; non-decimal codes render blank
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per clock.
module bin2bcd_seq #(
  parameter int unsigned VALUE_W    = 10,
  parameter int unsigned BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic                    carry,
  output logic [BCD_DIGITS*4-1:0] bcd
);

  localparam int unsigned BCD_W = BCD_DIGITS * 4;
  localparam int unsigned SR_W  = BCD_W + VALUE_W;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [CNT_W-1:0] cnt;

  // Add 3 to every BCD nibble that is 5 or more before the shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (sr[VALUE_W + 4*i +: 4] >= 4'd5) begin
        sr_adj[VALUE_W + 4*i +: 4] = sr[VALUE_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift datapath and bit counter; done is high during the cycle whose
  // closing edge performs the final shift, carry flags digits lost off the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      carry <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      carry <= 1'b0;
    end else if (start) begin
      sr    <= {{BCD_W{1'b0}}, bin};
      cnt   <= CNT_W'(VALUE_W);
      busy  <= 1'b1;
      done  <= (VALUE_W == 1);
      carry <= 1'b0;
    end else if (cnt != '0) begin
      sr    <= {sr_adj[SR_W-2:0], 1'b0};
      cnt   <= cnt - CNT_W'(1);
      busy  <= (cnt != CNT_W'(1));
      done  <= (cnt == CNT_W'(2));
      carry <= carry | sr_adj[SR_W-1];
    end else begin
      done  <= 1'b0;
    end
  end

  assign bcd = sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/display_valor_mux.sv
// Time-multiplexed seven-segment display of a latched binary amount.
module display_valor_mux #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned VALUE_W    = 10,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned LZB        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    valor,
  input  logic                  load,
  input  logic                  sinal_cancel,
  output logic                  busy,
  output logic [NUM_DIGITS-1:0] digitos,
  output logic [6:0]            segmentos,
  output logic                  Exibe_Valor
);

  import display_pkg::*;

  localparam int unsigned BCD_DIGITS = NUM_DIGITS + 1;
  localparam int unsigned BCD_W      = BCD_DIGITS * 4;
  localparam int unsigned BUF_W      = NUM_DIGITS * 4;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W      = $clog2(SCAN_DIV);

  state_t              state;
  state_t              state_next;
  logic [PRE_W-1:0]    pre;
  logic [PRE_W-1:0]    pre_next;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic [BUF_W-1:0]    disp_buf;
  logic [BUF_W-1:0]    buf_next;
  logic                ovf;
  logic                ovf_next;
  logic                exibe_next;
  logic                busy_next;
  logic [NUM_DIGITS-1:0] digitos_next;
  logic [6:0]          seg_next;
  logic [NUM_DIGITS-1:0] blank;
  logic                zero_above;
  logic                conv_start;
  logic                conv_done;
  logic                conv_carry;
  logic [BCD_W-1:0]    conv_bcd;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (sinal_cancel),
    .start (conv_start),
    .bin   (valor),
    .busy  (),
    .done  (conv_done),
    .carry (conv_carry),
    .bcd   (conv_bcd)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, display buffer capture and conversion start; cancel wins
  always_comb begin
    state_next = state;
    buf_next   = disp_buf;
    ovf_next   = ovf;
    exibe_next = Exibe_Valor;
    conv_start = 1'b0;
    case (state)
      IDLE, SHOW: begin
        if (load) begin
          state_next = CONV;
          conv_start = 1'b1;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = SHOW;
        buf_next   = conv_bcd[BUF_W-1:0];
        ovf_next   = (conv_bcd[BCD_W-1 -: 4] != 4'd0) || conv_carry;
        exibe_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (sinal_cancel) begin
      state_next = IDLE;
      conv_start = 1'b0;
      buf_next   = '0;
      ovf_next   = 1'b0;
      exibe_next = 1'b0;
    end
  end

  // busy follows CONV one cycle late so it covers exactly the shift cycles
  assign busy_next = (state == CONV) && !sinal_cancel;

  // Free-running digit-slot prescaler and scan index
  always_comb begin
    pre_next = pre + PRE_W'(1);
    idx_next = idx;
    if (pre == PRE_W'(SCAN_DIV - 1)) begin
      pre_next = '0;
      idx_next = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Leading-zero mask, walking from the most significant digit down
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      zero_above = zero_above && (buf_next[4*(int'(NUM_DIGITS)-1-i) +: 4] == 4'd0);
      blank[int'(NUM_DIGITS)-1-i] = (LZB != 0) && (i != int'(NUM_DIGITS)-1) && zero_above;
    end
  end

  // Digit enable and segment pattern for the upcoming scan slot
  always_comb begin
    digitos_next = '1;
    seg_next     = SEG_BLANK;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (exibe_next && (idx_next == IDX_W'(k)) && (ovf_next || !blank[k])) begin
        digitos_next[int'(NUM_DIGITS)-1-k] = 1'b0;
        seg_next = ovf_next ? SEG_DASH : bcd_to_seg(buf_next[4*k +: 4]);
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre         <= '0;
      idx         <= '0;
      disp_buf    <= '0;
      ovf         <= 1'b0;
      busy        <= 1'b0;
      Exibe_Valor <= 1'b0;
      digitos     <= '1;
      segmentos   <= SEG_BLANK;
    end else begin
      pre         <= pre_next;
      idx         <= idx_next;
      disp_buf    <= buf_next;
      ovf         <= ovf_next;
      busy        <= busy_next;
      Exibe_Valor <= exibe_next;
      digitos     <= digitos_next;
      segmentos   <= seg_next;
    end
  end

endmodule

// File: tb/tb_display_valor_mux.sv
// Scoreboard bench for display_valor_mux: three instances (LZB on, LZB off, 2 digits).
module tb_display_valor_mux;

  localparam int unsigned VW = 10;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] valor;
  logic          load;
  logic          sinal_cancel;

  logic       busy0, ev0, busy1, ev1, busy2, ev2;
  logic [3:0] dig0, dig1;
  logic [1:0] dig2;
  logic [6:0] seg0, seg1, seg2;

  logic [3:0] obs_dig  [3];
  logic [6:0] obs_seg  [3];
  logic       obs_ev   [3];
  logic       obs_busy [3];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  typedef struct { int value; int which; } exp_t;
  exp_t sb[$];

  display_valor_mux #(.NUM_DIGITS(4), .VALUE_W(VW), .SCAN_DIV(SD), .LZB(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .valor(valor), .load(load), .sinal_cancel(sinal_cancel),
    .busy(busy0), .digitos(dig0), .segmentos(seg0), .Exibe_Valor(ev0));
  display_valor_mux #(.NUM_DIGITS(4), .VALUE_W(VW), .SCAN_DIV(SD), .LZB(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .valor(valor), .load(load), .sinal_cancel(sinal_cancel),
    .busy(busy1), .digitos(dig1), .segmentos(seg1), .Exibe_Valor(ev1));
  display_valor_mux #(.NUM_DIGITS(2), .VALUE_W(VW), .SCAN_DIV(SD), .LZB(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .valor(valor), .load(load), .sinal_cancel(sinal_cancel),
    .busy(busy2), .digitos(dig2), .segmentos(seg2), .Exibe_Valor(ev2));

  assign obs_dig[0] = dig0;
  assign obs_dig[1] = dig1;
  assign obs_dig[2] = {2'b11, dig2};
  assign obs_seg[0] = seg0;
  assign obs_seg[1] = seg1;
  assign obs_seg[2] = seg2;
  assign obs_ev[0]  = ev0;
  assign obs_ev[1]  = ev1;
  assign obs_ev[2]  = ev2;
  assign obs_busy[0] = busy0;
  assign obs_busy[1] = busy1;
  assign obs_busy[2] = busy2;

  always #5 clk = ~clk;

  // Edges since reset release; scan slot after edge n is (n / SD) % digits
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int nd_of(input int which);
    return (which == 2) ? 2 : 4;
  endfunction

  function automatic int lzb_of(input int which);
    return (which == 1) ? 0 : 1;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference pattern for slot k of an instance showing value
  function automatic void exp_slot(input int value, input int which, input int k,
                                   output logic [3:0] dig, output logic [6:0] seg);
    int nd = nd_of(which);
    int p = 1;
    int lim = 1;
    bit blk;
    for (int i = 0; i < k; i++) p = p * 10;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    dig = 4'hF;
    seg = 7'h7F;
    if (value >= lim) begin
      dig = dig & ~(4'b0001 << (nd - 1 - k));
      seg = 7'b0111111;
    end else begin
      blk = (lzb_of(which) != 0) && (k > 0) && (value < p);
      if (!blk) begin
        dig = dig & ~(4'b0001 << (nd - 1 - k));
        seg = seg_of((value / p) % 10);
      end
    end
  endfunction

  task automatic observe(input int which, input int k, output logic [3:0] dig,
                         output logic [6:0] seg, output bit ok);
    ok  = 1'b0;
    dig = 'x;
    seg = 'x;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      if (((cyc / int'(SD)) % nd_of(which)) == k) begin
        ok  = 1'b1;
        dig = obs_dig[which];
        seg = obs_seg[which];
      end
    end
  endtask

  task automatic wait_result(input int which, output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (obs_busy[which] === 1'b1) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
  endtask

  task automatic do_load(input int value, input int which, input bit push);
    @(negedge clk);
    valor = VW'(value);
    load  = 1'b1;
    if (push) sb.push_back('{value, which});
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; sinal_cancel = 1'b0; valor = '0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      total++;
      if ({obs_dig[w], obs_seg[w], obs_ev[w], obs_busy[w]} !== {4'hF, 7'h7F, 1'b0, 1'b0})
        $display("FAIL reset_inst%0d: dig/seg/ev/busy=%h/%h/%b/%b need f/7f/0/0",
                 w, obs_dig[w], obs_seg[w], obs_ev[w], obs_busy[w]);
      else passed++;
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if ({dig0, seg0, ev0} !== {4'hF, 7'h7F, 1'b0})
      $display("FAIL idle_blank: dig/seg/ev=%h/%h/%b need f/7f/0", dig0, seg0, ev0);
    else passed++;
  endtask

  task automatic test_basic();
    int busy_cnt, ev_at;
    exp_t e; logic [3:0] od, xd; logic [6:0] os, xs; bit ok;
    do_load(1, 0, 1'b1);
    busy_cnt = 0; ev_at = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (busy0 === 1'b1) busy_cnt++;
      if (ev0 === 1'b1 && ev_at < 0) ev_at = i;
    end
    total++;
    if (busy_cnt !== 10) $display("FAIL busy_len: got %0d cycles need 10", busy_cnt);
    else passed++;
    total++;
    if (ev_at !== 11) $display("FAIL ev_latency: got edge t+%0d need t+11", ev_at);
    else passed++;
    e = sb.pop_front();
    for (int k = 0; k < nd_of(e.which); k++) begin
      observe(e.which, k, od, os, ok);
      exp_slot(e.value, e.which, k, xd, xs);
      total++;
      if (!ok) $display("FAIL basic_slot%0d: slot never reached need %0d", k, k);
      else if ({od, os} !== {xd, xs})
        $display("FAIL basic_slot%0d: got %b/%b need %b/%b", k, od, os, xd, xs);
      else passed++;
    end
  endtask

  task automatic test_value(input int value, input int which, input string nm);
    exp_t e; logic [3:0] od, xd; logic [6:0] os, xs; bit ok;
    do_load(value, which, 1'b1);
    wait_result(which, ok);
    total++;
    if (!ok || obs_ev[which] !== 1'b1)
      $display("FAIL %s_ev: done=%b ev=%b need 1/1", nm, ok, obs_ev[which]);
    else passed++;
    e = sb.pop_front();
    for (int k = 0; k < nd_of(e.which); k++) begin
      observe(e.which, k, od, os, ok);
      exp_slot(e.value, e.which, k, xd, xs);
      total++;
      if (!ok) $display("FAIL %s_slot%0d: slot never reached need %0d", nm, k, k);
      else if ({od, os} !== {xd, xs})
        $display("FAIL %s_slot%0d: got %b/%b need %b/%b", nm, k, od, os, xd, xs);
      else passed++;
    end
  endtask

  task automatic test_ignore_cancel();
    exp_t e; logic [3:0] od, xd; logic [6:0] os, xs; bit ok; int bad;
    do_load(20, 0, 1'b1);
    repeat (2) @(negedge clk);
    valor = VW'(50); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_result(0, ok);
    e = sb.pop_front();
    for (int k = 0; k < nd_of(e.which); k++) begin
      observe(e.which, k, od, os, ok);
      exp_slot(e.value, e.which, k, xd, xs);
      total++;
      if (!ok) $display("FAIL ignore_slot%0d: slot never reached need %0d", k, k);
      else if ({od, os} !== {xd, xs})
        $display("FAIL ignore_slot%0d: got %b/%b need %b/%b", k, od, os, xd, xs);
      else passed++;
    end
    @(negedge clk);
    sinal_cancel = 1'b1; load = 1'b1; valor = VW'(7);
    @(negedge clk);
    sinal_cancel = 1'b0; load = 1'b0;
    total++;
    if ({dig0, seg0, ev0, busy0} !== {4'hF, 7'h7F, 1'b0, 1'b0})
      $display("FAIL cancel_now: dig/seg/ev/busy=%h/%h/%b/%b need f/7f/0/0", dig0, seg0, ev0, busy0);
    else passed++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if ({dig0, ev0, busy0} !== {4'hF, 1'b0, 1'b0}) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL cancel_idle: got %0d active cycles need 0", bad);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [3:0] od, xd; logic [6:0] os, xs; bit ok; int bad;
    do_load(10, 0, 1'b1);
    wait_result(0, ok);
    e = sb.pop_front();
    total++;
    if (!ok || ev0 !== 1'b1) $display("FAIL b2b_first: done=%b ev=%b need 1/1", ok, ev0);
    else passed++;
    do_load(2, 0, 1'b1);
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_slot(e.value, 0, (cyc / int'(SD)) % 4, xd, xs);
      if ({ev0, busy0, dig0, seg0} !== {1'b1, 1'b1, xd, xs}) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL b2b_hold: got %0d cycles off \"10\" need 0", bad);
    else passed++;
    wait_result(0, ok);
    e = sb.pop_front();
    for (int k = 0; k < nd_of(e.which); k++) begin
      observe(e.which, k, od, os, ok);
      exp_slot(e.value, e.which, k, xd, xs);
      total++;
      if (!ok) $display("FAIL b2b_slot%0d: slot never reached need %0d", k, k);
      else if ({od, os} !== {xd, xs})
        $display("FAIL b2b_slot%0d: got %b/%b need %b/%b", k, od, os, xd, xs);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_load(300, 0, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (busy0 !== 1'b1) $display("FAIL midconv_busy: got %b need 1", busy0);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    for (int w = 0; w < 3; w++) begin
      total++;
      if ({obs_dig[w], obs_seg[w], obs_ev[w], obs_busy[w]} !== {4'hF, 7'h7F, 1'b0, 1'b0})
        $display("FAIL async_rst_inst%0d: dig/seg/ev/busy=%h/%h/%b/%b need f/7f/0/0",
                 w, obs_dig[w], obs_seg[w], obs_ev[w], obs_busy[w]);
      else passed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_value(100, 0, "hundred");
    test_value(5, 1, "nolzb");
    test_value(150, 2, "ovf");
    test_value(0, 0, "zero");
    test_ignore_cancel();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
